sync_shift_latch_595: RTL and testbench
=======================================

Name: sync_shift_latch_595

Overview:
- Synchronous emulation of a 74x595 8-bit serial-in/parallel-out shift register with output storage register.
- Counterpart in the other direction to the team's combinational gate parts: a serial bit stream goes in, parallel outputs come out, plus a cascade serial out.
- External SRCLK/RCLK/SRCLR_N pins are sampled in the single system clock domain, never used as clocks.
- Targets the same CPLD flow as the 74x logic-part family.

Parameters:
- WIDTH, 8, shift/storage register width.
- SYNC_STAGES, 2, synchronizer flops per asynchronous pin input (minimum 2).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous active-high reset.
- SER  input  1  serial data in.
- SRCLK  input  1  shift clock pin (asynchronous); its rising edge shifts.
- RCLK  input  1  storage clock pin (asynchronous); its rising edge latches.
- SRCLR_N  input  1  active-low shift-register clear (asynchronous pin, level sensitive).
- OE_N  input  1  active-low output enable for Q.
- Q  output  WIDTH  parallel outputs; Q[0]=QA … Q[WIDTH-1]=QH; high-Z when disabled.
- QH_S  output  1  cascade serial out = shift register MSB.

Behaviour:
- Reset values:
  - When RST=1 at a CLK edge: shift register = 0 and storage register = 0.
  - All synchronizer and edge-history flops for SRCLK/RCLK load 1, so a pin held high gives no spurious rising edge after reset.
  - SRCLR_N synchronizer loads 1.
  - QH_S=0. Q=0 if OE_N=0.
  - Reset overrides everything, including mid-sequence; any partially shifted data is lost.
- Synchronization:
  - SER is sampled through the same SYNC_STAGES chain as SRCLK, so data and clock stay aligned.
  - The rising-edge pulse srclk_rise is asserted for exactly one CLK cycle when the synchronized level goes 0→1. rclk_rise is produced the same way.
- Latency: a pin edge is acted on at the CLK edge SYNC_STAGES+1 cycles after first sampling. Default is 3 cycles, pin to register update.
- Shift: on srclk_rise with the clear inactive, shift <= {shift[WIDTH-2:0], ser_sync}.
- Clear:
  - While synchronized SRCLR_N=0, shift is held at 0 every cycle.
  - Clear has priority over a coincident srclk_rise.
  - Storage is NOT cleared.
- Latch: on rclk_rise, storage <= shift, using the value before any shift in the same cycle.
  - If srclk_rise and rclk_rise coincide, storage gets the pre-shift value. This keeps the storage register one stage behind the shift register when the two pins are tied together, as on the real part.
  - If clear and rclk_rise coincide, storage gets the pre-clear value.
- QH_S = shift[WIDTH-1], registered and always driven (unaffected by OE_N).
- Q = storage when OE_N=0; high-Z when OE_N=1.
  - OE_N is a combinational path to the output buffers, not synchronized.
  - Storage retains its value while disabled.
- Pin pulses shorter than one CLK period may be missed. Minimum SRCLK/RCLK high and low time is 2 CLK periods for guaranteed capture.
- No edge action on falling edges. A continuous high or low level produces no action.

Decomposition:
- Shared package:
  - WIDTH and SYNC_STAGES defaults.
  - Synchronizer reset constant (1).
  - Q index names QA..QH as localparams.
- One sub-module, pin_edge_sync:
  - Parameterized SYNC_STAGES flop chain plus edge-history flop.
  - Outputs: level_sync, rise_pulse. Reset loads all ones.
  - Instanced for SRCLK (with SER carried in a parallel chain) and RCLK.
  - SRCLR_N uses its level_sync output only.
- Top level holds the shift and storage registers and the Q tri-state.

Test Plan:
- Basic load: after RST, OE_N=0; shift SER bits 1,0,1,1,0,0,1,0 (MSB first) with 8 SRCLK pulses, each level held 4 CLK; then one RCLK pulse → Q=8'hB2, QH_S=1 after the 8th shift. Q stays 0 until the RCLK pulse.
- Tied clocks: SRCLK and RCLK driven from one source, SER=1 for 3 pulses → after the 3rd pulse shift=8'h07 and Q=8'h03, i.e. storage one stage behind.
- Clear priority: shift=8'hFF, storage=8'hFF; drop SRCLR_N during an SRCLK pulse → shift=0, QH_S=0, Q still 8'hFF. Next RCLK pulse → Q=0.
- Output enable: storage=8'h5A; OE_N=1 → Q all Z; OE_N=0 → Q=8'h5A with no CLK edge required.
- Reset mid-operation: after 4 shifts of SER=1, assert RST for 1 cycle with SRCLK held high → shift=0, storage=0, and no shift occurs while SRCLK remains high. The next clean pulse shifts exactly once.
- Latency and short-pulse check: single SRCLK rise → shift update on exactly the 3rd CLK edge after the pin rises. A 1-CLK-wide high glitch is not required to shift; check the bench tolerates either outcome only for pulses under 2 CLK.

Source files
------------

// File: rtl/sync_shift_latch_595_pkg.sv
// Shared constants for the synchronous 74x595 emulation: default sizes,
// synchronizer reset level and the QA..QH output index names.
package sync_shift_latch_595_pkg;

    // Default register width of the emulated part.
    localparam int WIDTH_DEFAULT       = 8;

    // Default and minimum depth of each pin synchronizer chain.
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int SYNC_STAGES_MIN     = 2;

    // Synchronizer and edge-history flops reset high. A pin already held
    // high when reset releases then gives no rising edge.
    localparam logic SYNC_RST_VAL      = 1'b1;

    // Parallel output bit names, matching the data-sheet pin letters.
    localparam int QA = 0;
    localparam int QB = 1;
    localparam int QC = 2;
    localparam int QD = 3;
    localparam int QE = 4;
    localparam int QF = 5;
    localparam int QG = 6;
    localparam int QH = 7;

    // Fewer than two stages is not a metastability-safe synchronizer,
    // so a smaller request is raised to the minimum.
    function automatic int clamp_stages(input int stages);
        return (stages < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : stages;
    endfunction

endpackage

// File: rtl/sync_shift_latch_595_if.sv
// Pin bundle of the emulated 74x595 (everything except CLK, RST and the
// tri-state Q bus). The master drives the pins, the slave is the part.
interface sync_shift_latch_595_if;
    import sync_shift_latch_595_pkg::*;

    logic SER;      // serial data in
    logic SRCLK;    // shift clock pin, asynchronous, rising edge shifts
    logic RCLK;     // storage clock pin, asynchronous, rising edge latches
    logic SRCLR_N;  // active-low shift register clear, level sensitive
    logic OE_N;     // active-low output enable for Q, combinational
    logic QH_S;     // cascade serial out = shift register MSB

    modport master (
        output SER,
        output SRCLK,
        output RCLK,
        output SRCLR_N,
        output OE_N,
        input  QH_S
    );

    modport slave (
        input  SER,
        input  SRCLK,
        input  RCLK,
        input  SRCLR_N,
        input  OE_N,
        output QH_S
    );

endinterface

// File: rtl/sync_shift_latch_595_pin_edge_sync.sv
// Synchronizer for one asynchronous pin, plus an optional data bit that
// travels in a parallel chain of the same depth so that it stays aligned
// with the pin. The chain and history flops reset to all ones. The data
// chain resets to zero. rise_pulse is high for exactly one CLK cycle
// after the synchronized level goes from 0 to 1.
module pin_edge_sync
    import sync_shift_latch_595_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
)(
    input  logic clk,
    input  logic rst,
    input  logic pin_in,
    input  logic data_in,
    output logic level_sync,
    output logic data_sync,
    output logic rise_pulse
);

    localparam int N = clamp_stages(SYNC_STAGES);

    logic [N-1:0] pin_sync_q;
    logic [N-1:0] pin_sync_d;
    logic [N-1:0] data_sync_q;
    logic [N-1:0] data_sync_d;
    logic         hist_q;
    logic         hist_d;

    // Next state: both chains shift toward the MSB. History remembers the last synchronized level.
    always_comb begin
        pin_sync_d  = {pin_sync_q[N-2:0], pin_in};
        data_sync_d = {data_sync_q[N-2:0], data_in};
        hist_d      = pin_sync_q[N-1];
    end

    // Chain and history registers, synchronous reset to the idle-high state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pin_sync_q  <= {N{SYNC_RST_VAL}};
            data_sync_q <= {N{1'b0}};
            hist_q      <= SYNC_RST_VAL;
        end else begin
            pin_sync_q  <= pin_sync_d;
            data_sync_q <= data_sync_d;
            hist_q      <= hist_d;
        end
    end

    assign level_sync = pin_sync_q[N-1];
    assign data_sync  = data_sync_q[N-1];
    // Decoded from flops only, so the pulse is clean and one cycle wide.
    assign rise_pulse = pin_sync_q[N-1] & ~hist_q;

endmodule

// File: rtl/sync_shift_latch_595.sv
// Synchronous 74x595: serial-in shift register, parallel storage register
// and tri-state Q outputs. SRCLK, RCLK and SRCLR_N are pins sampled in the
// CLK domain and never used as clocks. A pin edge updates the registers on
// the CLK edge SYNC_STAGES+1 cycles after the pin is first sampled.
module sync_shift_latch_595
    import sync_shift_latch_595_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
)(
    input  logic                  CLK,
    input  logic                  RST,
    sync_shift_latch_595_if.slave pins,
    output wire  [WIDTH-1:0]      Q
);

    localparam int STAGES = clamp_stages(SYNC_STAGES);

    logic             srclk_rise_s;
    logic             ser_sync_s;
    logic             rclk_rise_s;
    logic             srclr_n_sync_s;
    logic             srclk_level_unused_s;
    logic             rclk_level_unused_s;
    logic             rclk_data_unused_s;
    logic             srclr_data_unused_s;
    logic             srclr_rise_unused_s;

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] storage_q;
    logic [WIDTH-1:0] storage_d;
    logic             qh_s_q;
    logic             qh_s_d;

    // SER goes through the SRCLK chain, so the bit shifted in is the SER
    // value that was on the pin when SRCLK rose.
    pin_edge_sync #(.SYNC_STAGES(STAGES)) u_srclk_sync (
        .clk        (CLK),
        .rst        (RST),
        .pin_in     (pins.SRCLK),
        .data_in    (pins.SER),
        .level_sync (srclk_level_unused_s),
        .data_sync  (ser_sync_s),
        .rise_pulse (srclk_rise_s)
    );

    pin_edge_sync #(.SYNC_STAGES(STAGES)) u_rclk_sync (
        .clk        (CLK),
        .rst        (RST),
        .pin_in     (pins.RCLK),
        .data_in    (1'b0),
        .level_sync (rclk_level_unused_s),
        .data_sync  (rclk_data_unused_s),
        .rise_pulse (rclk_rise_s)
    );

    // The clear is level sensitive, so only its synchronized level is used.
    pin_edge_sync #(.SYNC_STAGES(STAGES)) u_srclr_sync (
        .clk        (CLK),
        .rst        (RST),
        .pin_in     (pins.SRCLR_N),
        .data_in    (1'b0),
        .level_sync (srclr_n_sync_s),
        .data_sync  (srclr_data_unused_s),
        .rise_pulse (srclr_rise_unused_s)
    );

    // Next state of shift, storage and cascade out. Clear wins over shift.
    // Storage always takes the pre-shift, pre-clear value, so with tied
    // clocks it stays one stage behind.
    always_comb begin
        shift_d   = shift_q;
        storage_d = storage_q;
        qh_s_d    = qh_s_q;

        if (!srclr_n_sync_s) begin
            shift_d = {WIDTH{1'b0}};
        end else if (srclk_rise_s) begin
            shift_d = {shift_q[WIDTH-2:0], ser_sync_s};
        end else begin
            shift_d = shift_q;
        end

        if (rclk_rise_s) begin
            storage_d = shift_q;
        end else begin
            storage_d = storage_q;
        end

        // Cascade out mirrors the MSB the shift register holds next cycle.
        qh_s_d = shift_d[WIDTH-1];
    end

    // Shift, storage and cascade registers. Reset clears all of them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_q   <= {WIDTH{1'b0}};
            storage_q <= {WIDTH{1'b0}};
            qh_s_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            storage_q <= storage_d;
            qh_s_q    <= qh_s_d;
        end
    end

    assign pins.QH_S = qh_s_q;

    // OE_N gates the output buffers directly. It is not synchronized, and
    // storage holds its value while Q floats.
    assign Q = pins.OE_N ? {WIDTH{1'bz}} : storage_q;

endmodule

// File: tb/tb_sync_shift_latch_595.sv
// Self-checking bench for sync_shift_latch_595: a vector table of pin
// operations with hand-computed results, hand-written multi-cycle corner
// sequences, and random operations checked against an event-level model.
// Q is read through a pulled-up net, so a floating bus reads as all ones.
module tb_sync_shift_latch_595;
    import sync_shift_latch_595_pkg::*;

    logic clk = 1'b0;
    logic rst;
    tri1 [7:0] q_w;

    sync_shift_latch_595_if ifc ();

    sync_shift_latch_595 #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .CLK  (clk),
        .RST  (rst),
        .pins (ifc),
        .Q    (q_w)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        bit         do_rst;
        bit         ser;
        bit         srclk;
        bit         rclk;
        bit         clr;
        bit         oe_n;
        logic [7:0] exp_q;
        bit         exp_qhs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input bit r, input bit s, input bit sc,
                       input bit rc, input bit c, input bit oe,
                       input logic [7:0] q, input bit qhs);
        vec_t v;
        v.name = n; v.do_rst = r; v.ser = s; v.srclk = sc; v.rclk = rc;
        v.clr = c; v.oe_n = oe; v.exp_q = q; v.exp_qhs = qhs;
        vecs.push_back(v);
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // One pin operation: raise the selected pins (clear drops SRCLR_N),
    // hold 4 CLK, release, hold 4 CLK, then land on a falling edge.
    task automatic do_op(input bit do_rst, input bit ser, input bit srclk,
                         input bit rclk, input bit clr, input bit oe_n);
        @(posedge clk); #1;
        ifc.OE_N = oe_n;
        if (do_rst) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (3) @(posedge clk);
        end else begin
            ifc.SER     = ser;
            ifc.SRCLK   = srclk;
            ifc.RCLK    = rclk;
            ifc.SRCLR_N = ~clr;
            repeat (4) @(posedge clk); #1;
            ifc.SRCLK   = 1'b0;
            ifc.RCLK    = 1'b0;
            ifc.SRCLR_N = 1'b1;
            repeat (4) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic shift_byte(input logic [7:0] val);
        for (int i = 7; i >= 0; i--) do_op(1'b0, val[i], 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    logic [7:0] m_shift, m_store, old_shift, exp_q;
    bit         r_ser, r_sc, r_rc, r_clr, r_oe;

    initial begin
        rst         = 1'b1;
        ifc.SER     = 1'b0;
        ifc.SRCLK   = 1'b0;
        ifc.RCLK    = 1'b0;
        ifc.SRCLR_N = 1'b1;
        ifc.OE_N    = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check8("reset_q", q_w, 8'h00);
        check8("reset_qhs", {7'd0, ifc.QH_S}, 8'h00);

        // Basic load of 1,0,1,1,0,0,1,0 (MSB first), then latch.
        add("load1", 0, 1, 1, 0, 0, 0, 8'h00, 0);
        add("load2", 0, 0, 1, 0, 0, 0, 8'h00, 0);
        add("load3", 0, 1, 1, 0, 0, 0, 8'h00, 0);
        add("load4", 0, 1, 1, 0, 0, 0, 8'h00, 0);
        add("load5", 0, 0, 1, 0, 0, 0, 8'h00, 0);
        add("load6", 0, 0, 1, 0, 0, 0, 8'h00, 0);
        add("load7", 0, 1, 1, 0, 0, 0, 8'h00, 0);
        add("load8", 0, 0, 1, 0, 0, 0, 8'h00, 1);
        add("load_latch", 0, 0, 0, 1, 0, 0, 8'hB2, 1);
        // Tied clocks: storage trails shift by one stage.
        add("tied_rst", 1, 0, 0, 0, 0, 0, 8'h00, 0);
        add("tied1", 0, 1, 1, 1, 0, 0, 8'h00, 0);
        add("tied2", 0, 1, 1, 1, 0, 0, 8'h01, 0);
        add("tied3", 0, 1, 1, 1, 0, 0, 8'h03, 0);
        // Clear priority over a coincident shift, storage untouched.
        add("clr_rst", 1, 0, 0, 0, 0, 0, 8'h00, 0);
        add("ff1", 0, 1, 1, 0, 0, 0, 8'h00, 0);
        add("ff2", 0, 1, 1, 0, 0, 0, 8'h00, 0);
        add("ff3", 0, 1, 1, 0, 0, 0, 8'h00, 0);
        add("ff4", 0, 1, 1, 0, 0, 0, 8'h00, 0);
        add("ff5", 0, 1, 1, 0, 0, 0, 8'h00, 0);
        add("ff6", 0, 1, 1, 0, 0, 0, 8'h00, 0);
        add("ff7", 0, 1, 1, 0, 0, 0, 8'h00, 0);
        add("ff8", 0, 1, 1, 0, 0, 0, 8'h00, 1);
        add("ff_latch", 0, 0, 0, 1, 0, 0, 8'hFF, 1);
        add("clr_vs_shift", 0, 1, 1, 0, 1, 0, 8'hFF, 0);
        add("clr_latch", 0, 0, 0, 1, 0, 0, 8'h00, 0);
        // Clear with a coincident latch: storage keeps the pre-clear value.
        add("pc1", 0, 1, 1, 0, 0, 0, 8'h00, 0);
        add("pc2", 0, 1, 1, 0, 0, 0, 8'h00, 0);
        add("clr_and_latch", 0, 0, 0, 1, 1, 0, 8'h03, 0);
        add("latch_cleared", 0, 0, 0, 1, 0, 0, 8'h00, 0);
        // Disabled output floats (pulled up), enabled again shows storage.
        add("oe_shift", 0, 1, 1, 0, 0, 0, 8'h00, 0);
        add("oe_latch_off", 0, 0, 0, 1, 0, 1, 8'hFF, 0);
        add("oe_back_on", 0, 0, 0, 0, 0, 0, 8'h01, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].do_rst, vecs[i].ser, vecs[i].srclk, vecs[i].rclk,
                  vecs[i].clr, vecs[i].oe_n);
            check8({vecs[i].name, "_q"}, q_w, vecs[i].exp_q);
            check8({vecs[i].name, "_qhs"}, {7'd0, ifc.QH_S}, {7'd0, vecs[i].exp_qhs});
        end

        // Output enable toggles act without any CLK edge.
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        shift_byte(8'h5A);
        do_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check8("oe_stored", q_w, 8'h5A);
        @(negedge clk);
        ifc.OE_N = 1'b1;
        #1;
        check8("oe_float", q_w, 8'hFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        ifc.OE_N = 1'b0;
        #1;
        check8("oe_comb_on", q_w, 8'h5A);

        // Reset in the middle of operation with SRCLK held high.
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check8("mid_pre_q", q_w, 8'h0F);
        @(posedge clk); #1;
        ifc.SER = 1'b1;
        ifc.SRCLK = 1'b1;
        repeat (5) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check8("mid_rst_q", q_w, 8'h00);
        check8("mid_rst_qhs", {7'd0, ifc.QH_S}, 8'h00);
        ifc.RCLK = 1'b1;
        repeat (4) @(posedge clk); #1;
        ifc.RCLK = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check8("mid_no_spurious", q_w, 8'h00);
        ifc.SRCLK = 1'b0;
        repeat (4) @(posedge clk);
        do_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check8("mid_one_shift", q_w, 8'h01);

        // Latency: the pin rises just after an edge, QH_S moves on edge 3.
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        shift_byte(8'h40);
        @(posedge clk); #1;
        ifc.SER = 1'b0;
        ifc.SRCLK = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            check8($sformatf("latency_edge%0d", e), {7'd0, ifc.QH_S},
                   (e == 3) ? 8'h01 : 8'h00);
        end
        repeat (3) @(posedge clk); #1;
        ifc.SRCLK = 1'b0;
        repeat (4) @(posedge clk);

        // One-CLK glitch: may shift once or not at all, never more.
        @(posedge clk); #1;
        ifc.SER = 1'b1;
        ifc.SRCLK = 1'b1;
        @(posedge clk); #1;
        ifc.SRCLK = 1'b0;
        repeat (6) @(posedge clk);
        do_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (!(q_w === 8'h80 || q_w === 8'h01)) begin
            n_err++;
            $display("FAIL glitch_q: actual=%h required=80 or 01", q_w);
        end

        // Random operations against the event-level model.
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_shift = 8'h00;
        m_store = 8'h00;
        for (int i = 0; i < 60; i++) begin
            r_ser = 1'($urandom_range(0, 1));
            r_sc  = 1'($urandom_range(0, 1));
            r_rc  = 1'($urandom_range(0, 1));
            r_clr = ($urandom_range(0, 7) == 0);
            r_oe  = ($urandom_range(0, 3) == 0);
            do_op(1'b0, r_ser, r_sc, r_rc, r_clr, r_oe);
            old_shift = m_shift;
            if (r_clr)     m_shift = 8'h00;
            else if (r_sc) m_shift = ((m_shift << 1) | {7'd0, r_ser}) & 8'hFF;
            if (r_rc)      m_store = old_shift;
            exp_q = r_oe ? 8'hFF : m_store;
            check8($sformatf("rand%0d_q", i), q_w, exp_q);
            check8($sformatf("rand%0d_qhs", i), {7'd0, ifc.QH_S}, {7'd0, m_shift[QH]});
        end
        check8("rand_final_qa", {7'd0, ifc.QH_S}, {7'd0, m_shift[QH - QA]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
